// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder.
// Strips E0/F0 prefix bytes from the receiver byte stream, assembles
// {extended, release, code} key events and buffers them in a small
// first-word-fall-through FIFO with a valid/ready consumer interface.
// Optional build macro PS2_ASCII_EN adds shift tracking and an ASCII
// lookup whose result is stored alongside each FIFO entry.
module ps2_scancode_decoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic [7:0] evt_ascii,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
`ifdef PS2_ASCII_EN
    localparam int unsigned EW = 18;
`else
    localparam int unsigned EW = 10;
`endif

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t        state;
    logic          valid_q;
    logic          byte_stb;
    logic          is_e0;
    logic          is_f0;
    logic          emit;
    logic          ev_ext;
    logic          ev_rel;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          accept;

    assign byte_stb = valid_in & ~valid_q;
    assign is_e0    = (data_in == 8'hE0);
    assign is_f0    = (data_in == 8'hF0);

    // Edge detect on the receiver valid level: one byte per rising edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= valid_in;
    end

    // Event assembly: any non-prefix byte closes the event using the prefix state
    always_comb begin
        emit   = byte_stb & ~is_e0 & ~is_f0;
        ev_ext = (state == EXT) || (state == EXT_BRK);
        ev_rel = (state == BRK) || (state == EXT_BRK);
    end

    // Prefix FSM, advanced only on a byte strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (byte_stb) begin
            case (state)
                IDLE: begin
                    if (is_e0)      state <= EXT;
                    else if (is_f0) state <= BRK;
                end
                EXT: begin
                    if (is_f0)       state <= EXT_BRK;
                    else if (!is_e0) state <= IDLE;
                end
                BRK: begin
                    if (is_e0)       state <= EXT_BRK;
                    else if (!is_f0) state <= IDLE;
                end
                EXT_BRK: begin
                    if (!is_e0 && !is_f0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PS2_ASCII_EN
    logic       shift_l;
    logic       shift_r;
    logic [7:0] ascii;

    // Shift key tracking from non-extended make/break events
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (emit && !ev_ext) begin
            if (data_in == 8'h12) shift_l <= ~ev_rel;
            if (data_in == 8'h59) shift_r <= ~ev_rel;
        end
    end

    // ASCII lookup using the shift state in effect before this event
    always_comb begin
        ascii = '0;
        case (data_in)
            8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;  8'h66: ascii = 8'h08;
            default: ascii = '0;
        endcase
        if (ev_ext || ev_rel)
            ascii = '0;
        else if ((shift_l || shift_r) && ascii >= 8'h61 && ascii <= 8'h7A)
            ascii = ascii - 8'h20;
    end

    assign entry     = {ev_ext, ev_rel, data_in, ascii};
    assign evt_ascii = evt_valid ? head[7:0] : 8'h00;
`else
    assign entry     = {ev_ext, ev_rel, data_in};
    assign evt_ascii = 8'h00;
`endif

    assign full   = (count == (AW+1)'(DEPTH));
    assign pop    = evt_valid & evt_ready;
    // A push into a full FIFO is still accepted when the head leaves this cycle
    assign accept = emit & (~full | pop);
    assign head   = mem[rd_ptr];

    assign evt_valid   = (count != '0);
    assign evt_ext     = evt_valid & head[EW-1];
    assign evt_release = evt_valid & head[EW-2];
    assign evt_code    = evt_valid ? head[EW-3 -: 8] : 8'h00;

    // FIFO storage write
    always_ff @(posedge clock) begin
        if (accept) mem[wr_ptr] <= entry;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (emit && full && !pop) overflow <= 1'b1;
        end
    end

endmodule
